fpu_sp_round_pack: RTL
======================

FPU_SP_ROUND_PACK -- requirements
Module: fpu_sp_round_pack

Interface
REQ-001 The parameter list SHALL be: WIDTH, 32, result word width (only 32 supported).
REQ-002 The parameter list SHALL be: EXP_W, 10, signed biased input-exponent width.
REQ-003 Port clk SHALL be: input, 1 bit, single clock, all state on rising edge.
REQ-004 Port rst SHALL be: input, 1 bit, asynchronous active-high reset.
REQ-005 Port in_valid SHALL be: input, 1 bit, upstream product valid.
REQ-006 Port in_ready SHALL be: output, 1 bit, stage can accept a product.
REQ-007 Port in_sign SHALL be: input, 1 bit, product sign (A sign XOR B sign).
REQ-008 Port in_exp SHALL be: input, EXP_W bits, two's-complement A_exp+B_exp-127 (range -127..383).
REQ-009 Port in_mant SHALL be: input, 48 bits, raw 24x24 significand product.
REQ-010 Port in_cls SHALL be: input, 2 bits, operand class: 0 normal, 1 zero, 2 inf, 3 NaN.
REQ-011 Port out_valid SHALL be: output, 1 bit, result valid.
REQ-012 Port out_ready SHALL be: input, 1 bit, downstream accepts result.
REQ-013 Port result SHALL be: output, WIDTH bits, IEEE-754 single result.
REQ-014 Port flags SHALL be: output, 3 bits, {overflow, underflow, inexact}, qualified by out_valid.

Function
REQ-015 A transfer SHALL occur on a cycle where valid and ready are both high; this applies to both in and out.
REQ-016 The block SHALL be a 2-stage pipeline, S1 normalize then S2 round/pack, with latency exactly 2 cycles from input transfer to out_valid when not stalled.
REQ-017 A stage SHALL advance when it is empty or the next stage advances; in_ready SHALL be high when S1 is empty or S1 advances. Full throughput is one item per cycle.
REQ-018 Data in a stalled stage SHALL be held unchanged, and no item SHALL be dropped or duplicated under any out_ready pattern.
REQ-019 S1: if in_mant[47]=1, then sig=in_mant[47:24], guard=in_mant[23], sticky=OR(in_mant[22:0]), and exp=in_exp+1; otherwise sig=in_mant[46:23], guard=in_mant[22], sticky=OR(in_mant[21:0]), and exp=in_exp.
REQ-020 S2 SHALL round to nearest even: increment sig when guard=1 and (sticky=1 or sig[0]=1).
REQ-021 When rounding carries out of sig, sig SHALL become 1.0 and exp SHALL increment.
REQ-022 inexact SHALL equal guard OR sticky for normal-class results.
REQ-023 A final exp of 255 or more SHALL give {sign,8'hFF,23'h0} with overflow=1 and inexact=1.
REQ-024 A final exp of 0 or less SHALL give {sign,31'h0} (flush-to-zero, no subnormals) with underflow=1 and inexact=1.
REQ-025 For class 1 the result SHALL be {sign,31'h0}; class 2 SHALL give {sign,8'hFF,23'h0}; class 3 SHALL give 32'h7FC00000. All flags SHALL be 0 for these classes.
REQ-026 Class SHALL be carried through S1 alongside the data, and the normalize/round datapath SHALL be ignored for non-normal classes.

Reset
REQ-027 While rst is high, out_valid, both stage-valid bits and flags SHALL be 0, result SHALL be 32'h0, and in_ready SHALL be 0.
REQ-028 Assertion of rst mid-operation SHALL discard all in-flight items immediately.
REQ-029 in_ready SHALL rise in the first cycle after rst deasserts.

Structure
REQ-030 Package fpu_sp_pkg SHALL hold: class encodings, the QNAN constant 32'h7FC00000, BIAS=127, EXP_MAX=255, and the flag bit positions.
REQ-031 Sub-module fpu_sp_rne_round SHALL be combinational: sig, guard and sticky in; rounded sig, carry and inexact out. It SHALL be instantiated in S2.

Verification
REQ-032 Input in_mant=48'h900000000000, in_exp=127, sign 0, class 0 -> after 2 cycles result=32'h40100000 (2.25), flags=0.
REQ-033 Input in_mant=48'h400000C00000, in_exp=127 -> result=32'h3F800002, inexact=1 (tie rounds up to even); with in_mant=48'h400000400000 -> result=32'h3F800000, inexact=1.
REQ-034 Input in_mant=48'h7FFFFFC00000, in_exp=127 -> round carry gives result=32'h40000000; in_exp=254 with in_mant[47]=1 -> result=32'h7F800000 with overflow=1; in_exp=-5 -> result=32'h0 with underflow=1.
REQ-035 Input of 4 back-to-back items with out_ready low for cycles 2-5 -> in_ready drops once both stages are full, and all 4 results emerge in order with no loss.
REQ-036 Input of class 3 followed by class 2 with sign 1 -> results 32'h7FC00000 then 32'hFF800000; rst asserted with 2 items in flight -> out_valid=0 next edge, and no stale item appears after release.

Source files
------------

// File: rtl/fpu_sp_pkg.sv
// Shared definitions for the single-precision round/pack stage:
// operand classes, special result constants, exponent limits, flag layout.
package fpu_sp_pkg;

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_cls_e;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam int          BIAS    = 127;
    localparam int          EXP_MAX = 255;

    // Bit positions inside the 3-bit flags word {overflow, underflow, inexact}.
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    // Normalised significand plus rounding bits, as held between S1 and S2.
    typedef struct packed {
        logic        sign;
        fp_cls_e     cls;
        logic [23:0] sig;
        logic        guard;
        logic        sticky;
    } s1_payload_t;

endpackage

// File: rtl/fpu_sp_rne_round.sv
// Combinational round-to-nearest-even on a 24-bit significand.
// On carry-out the significand is returned as 1.0 so the caller only
// has to bump the exponent.
module fpu_sp_rne_round (
    input  logic [23:0] sig_i,
    input  logic        guard_i,
    input  logic        sticky_i,
    output logic [23:0] sig_o,
    output logic        carry_o,
    output logic        inexact_o
);

    logic        inc;
    logic [24:0] sum;

    // Increment on guard when above half or on an exact tie with an odd LSB.
    // NOTE: combinational blocks use blocking '=' so later lines see the values computed above them.
    always_comb begin
        inc       = guard_i & (sticky_i | sig_i[0]);
        sum       = {1'b0, sig_i} + {24'd0, inc};
        carry_o   = sum[24];
        sig_o     = sum[24] ? 24'h80_0000 : sum[23:0];
        inexact_o = guard_i | sticky_i;
    end

endmodule

// File: rtl/fpu_sp_round_pack.sv
// Two-stage normalize / round-and-pack back end of a single-precision
// multiplier. S1 aligns the 48-bit product and extracts guard/sticky,
// S2 rounds to nearest even and packs an IEEE-754 word with flags.
// Valid/ready handshake on both sides, full throughput, no bubbles needed.
module fpu_sp_round_pack
    import fpu_sp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int EXP_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [47:0]      in_mant,
    input  logic [1:0]       in_cls,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);

    localparam logic signed [EXP_W:0] ONE_S     = (EXP_W+1)'(1);
    localparam logic signed [EXP_W:0] ZERO_S    = '0;
    localparam logic signed [EXP_W:0] EXP_MAX_S = (EXP_W+1)'(EXP_MAX);

    // Pipeline control.
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_adv, s2_adv;

    // S1 state: normalised payload and exponent (one extra bit for the +1).
    s1_payload_t             s1_q, s1_d;
    logic signed [EXP_W:0]   s1_exp_q, s1_exp_d;

    // S2 state: packed result and flags.
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       flags_q, flags_d;

    // Rounder interface.
    logic [23:0]           rnd_sig;
    logic                  rnd_carry;
    logic                  rnd_inexact;
    logic signed [EXP_W:0] final_exp;
    logic signed [EXP_W:0] in_exp_ext;

    assign s2_adv    = !s2_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = !rst && s1_adv;
    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    assign in_exp_ext = $signed({in_exp[EXP_W-1], in_exp});

    // S1 next state: capture and normalise a new product when S1 advances.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s1_exp_d   = s1_exp_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            s1_d.sign  = in_sign;
            s1_d.cls   = fp_cls_e'(in_cls);
            if (in_mant[47]) begin
                s1_d.sig    = in_mant[47:24];
                s1_d.guard  = in_mant[23];
                s1_d.sticky = |in_mant[22:0];
                s1_exp_d    = in_exp_ext + ONE_S;
            end else begin
                s1_d.sig    = in_mant[46:23];
                s1_d.guard  = in_mant[22];
                s1_d.sticky = |in_mant[21:0];
                s1_exp_d    = in_exp_ext;
            end
        end
    end

    fpu_sp_rne_round u_rne_round (
        .sig_i     (s1_q.sig),
        .guard_i   (s1_q.guard),
        .sticky_i  (s1_q.sticky),
        .sig_o     (rnd_sig),
        .carry_o   (rnd_carry),
        .inexact_o (rnd_inexact)
    );

    assign final_exp = s1_exp_q + (rnd_carry ? ONE_S : ZERO_S);

    // S2 next state: pack the rounded value or a special-class constant.
    always_comb begin
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        flags_d    = flags_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            flags_d    = '0;
            unique case (s1_q.cls)
                CLS_ZERO: result_d = {s1_q.sign, 31'h0};
                CLS_INF:  result_d = {s1_q.sign, 8'hFF, 23'h0};
                CLS_NAN:  result_d = QNAN;
                default: begin
                    if (final_exp >= EXP_MAX_S) begin
                        result_d           = {s1_q.sign, 8'hFF, 23'h0};
                        flags_d[FLAG_OVF]  = 1'b1;
                        flags_d[FLAG_INX]  = 1'b1;
                    end else if (final_exp <= ZERO_S) begin
                        // No subnormal support: flush to signed zero.
                        result_d           = {s1_q.sign, 31'h0};
                        flags_d[FLAG_UNF]  = 1'b1;
                        flags_d[FLAG_INX]  = 1'b1;
                    end else begin
                        result_d           = {s1_q.sign, final_exp[7:0], rnd_sig[22:0]};
                        flags_d[FLAG_INX]  = rnd_inexact;
                    end
                end
            endcase
        end
    end

    // State registers; reset empties both stages and clears the output word.
    // NOTE: datapath registers are reset too so result/flags read as zero during reset, not just the valids.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s1_exp_q   <= '0;
            result_q   <= '0;
            flags_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s1_exp_q   <= s1_exp_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
        end
    end

endmodule
